mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit for the EX stage. Computes MULT/MULTU/DIV/DIVU into HI/LO.

---
 rtl/mult_div_unit_pkg.sv | 23 ++
 rtl/mult_div_unit_if.sv | 28 ++
 rtl/mult_div_unit_negate.sv | 13 +
 rtl/mult_div_unit.sv | 145 ++++++++++++++
 tb/tb_mult_div_unit.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states, counter sizing.
// Pure declarations; no logic, no latency, no backpressure.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CALC  = 2'b01,
    S_FIXUP = 2'b10
  } mdu_state_e;

  // The step counter must hold WIDTH itself, so it needs one bit beyond log2.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
// No storage; the unit is the slave, the issuing stage is the master.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output busy, done, dz, hi, lo
  );
endinterface

// File: rtl/mult_div_unit_negate.sv
// Conditional two's-complement negation, used for operand magnitudes and result sign fixup.
// Purely combinational: zero latency, no backpressure.
module mdu_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in,
  input  logic             neg,
  output logic [WIDTH-1:0] out
);

  assign out = neg ? ((~in) + WIDTH'(1)) : in;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU into HI/LO, plus MTHI/MTLO writes; result WIDTH+2 edges after start.
// No backpressure: start/mthi/mtlo are ignored while busy, the hazard logic stalls on busy instead.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  mult_div_unit_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  mdu_state_e       state_q, state_d;
  mdu_op_e          op_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] a_q, opnd_q, acc_hi_q, acc_lo_q, hi_q, lo_q;
  logic             neg_res_q, neg_rem_q, done_q, dz_q;

  mdu_op_e          op_in;
  logic             in_signed, in_mult, sa, sb;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign op_in     = mdu_op_e'(bus.op);
  assign in_signed = (op_in == MDU_MULT) || (op_in == MDU_DIV);
  assign in_mult   = (op_in == MDU_MULT) || (op_in == MDU_MULTU);
  assign sa        = in_signed & bus.a[WIDTH-1];
  assign sb        = in_signed & bus.b[WIDTH-1];

  mdu_negate #(.WIDTH(WIDTH)) u_abs_a (.in(bus.a), .neg(sa), .out(a_abs));
  mdu_negate #(.WIDTH(WIDTH)) u_abs_b (.in(bus.b), .neg(sb), .out(b_abs));

  logic             is_div, dz_now;
  logic [WIDTH:0]   add_sum, rem_sh, diff;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign is_div = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
  assign dz_now = is_div && (opnd_q == '0);

  // Mult shifts the product right through {acc_hi,acc_lo}; div shifts the dividend left out of acc_lo.
  always_comb begin
    add_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, opnd_q};
    step_hi = add_sum[WIDTH:1];
    step_lo = {add_sum[0], acc_lo_q[WIDTH-1:1]};
    if (is_div) begin
      step_hi = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], ~diff[WIDTH]};
    end
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fin_hi, fin_lo;

  mdu_negate #(.WIDTH(2*WIDTH)) u_fix_prod (.in({acc_hi_q, acc_lo_q}), .neg(neg_res_q), .out(prod_fix));
  mdu_negate #(.WIDTH(WIDTH))   u_fix_quo  (.in(acc_lo_q), .neg(neg_res_q), .out(quo_fix));
  mdu_negate #(.WIDTH(WIDTH))   u_fix_rem  (.in(acc_hi_q), .neg(neg_rem_q), .out(rem_fix));

  always_comb begin
    fin_hi = prod_fix[2*WIDTH-1:WIDTH];
    fin_lo = prod_fix[WIDTH-1:0];
    if (dz_now) begin
      fin_hi = a_q;
      fin_lo = '1;
    end else if (is_div) begin
      fin_hi = rem_fix;
      fin_lo = quo_fix;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_CALC;
      S_CALC:  if (count_q == '0) state_d = S_FIXUP;
      S_FIXUP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= MDU_MULT;
      count_q   <= '0;
      a_q       <= '0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            op_q      <= op_in;
            a_q       <= bus.a;
            opnd_q    <= in_mult ? a_abs : b_abs;
            acc_hi_q  <= '0;
            acc_lo_q  <= in_mult ? b_abs : a_abs;
            count_q   <= CW'(WIDTH);
            neg_res_q <= sa ^ sb;
            neg_rem_q <= sa;
          end else begin
            if (bus.mthi) hi_q <= bus.wdata;
            if (bus.mtlo) lo_q <= bus.wdata;
          end
        end
        S_CALC: begin
          if (count_q != '0) begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
            count_q  <= count_q - CW'(1);
          end
        end
        S_FIXUP: begin
          hi_q   <= fin_hi;
          lo_q   <= fin_lo;
          done_q <= 1'b1;
          dz_q   <= dz_now;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.dz   = dz_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, random ops against an arithmetic model,
// and hand sequences for MTHI/MTLO, start collisions, mid-op restarts and asynchronous reset.
module tb_mult_div_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic         exp_dz;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero and % follows the dividend.
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
    longint       sa, sb, q, r;
    logic [63:0]  p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = '0;
    lo = '0;
    if (op[1] && b == '0) begin
      dz = 1'b1;
      hi = a;
      lo = '1;
    end else begin
      case (op)
        2'b00: p = 64'(sa * sb);
        2'b01: p = {32'b0, a} * {32'b0, b};
        2'b10: begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
        default: p = {a % b, a / b};
      endcase
      hi = p[63:32];
      lo = p[31:0];
    end
  endfunction

  // One complete operation: issue, watch busy/hold/latency, compare the result and the done pulse.
  task automatic exec(input string name, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit mt_with_start, input bit disturb,
                      input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input logic exp_dz);
    int lat;
    bit hold_ok;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    if (mt_with_start) begin
      bus.mthi  = 1'b1;
      bus.mtlo  = 1'b1;
      bus.wdata = 32'h1111_1111;
    end
    tick();
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    hold_ok = bus.busy && !bus.done && bus.hi == m_hi && bus.lo == m_lo;
    lat = 0;
    while (!bus.done && lat < 100) begin
      if (disturb && lat == 10) begin
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
      end
      tick();
      lat++;
      if (disturb && lat == 11) begin
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
      end
      if (!bus.done)
        hold_ok = hold_ok && bus.busy && !bus.dz && bus.hi == m_hi && bus.lo == m_lo;
    end
    check({name, " latency"}, 64'(lat), 64'(LAT));
    check({name, " hold"}, 64'(hold_ok), 64'd1);
    check({name, " hi"}, 64'(bus.hi), 64'(exp_hi));
    check({name, " lo"}, 64'(bus.lo), 64'(exp_lo));
    check({name, " dz/busy"}, {62'b0, bus.dz, bus.busy}, {62'b0, exp_dz, 1'b0});
    m_hi = exp_hi;
    m_lo = exp_lo;
    tick();
    check({name, " pulse"}, {61'b0, bus.done, bus.dz, bus.busy}, 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    logic [W-1:0] r_hi, r_lo, ra, rb;
    logic         r_dz;
    logic [1:0]   rop;

    vecs = '{
      '{"mult_neg",   2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0},
      '{"multu_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0},
      '{"div_neg",    2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0},
      '{"divu_small", 2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0},
      '{"divu_zero",  2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1},
      '{"div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0},
      '{"div_zero",   2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1},
      '{"div_negdiv", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0},
      '{"mult_min",   2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0},
      '{"multu_min",  2'b01, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 1'b0}
    };

    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.wdata = '0;

    #3;
    check("reset outputs", {bus.busy, bus.done, bus.dz, bus.hi, bus.lo}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    foreach (vecs[i])
      exec(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0,
           vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dz);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom >> $urandom_range(0, 31);
      rb  = ($urandom_range(0, 7) == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) ra = $urandom;
      model(rop, ra, rb, r_hi, r_lo, r_dz);
      exec($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, 1'b0, 1'b0, r_hi, r_lo, r_dz);
    end

    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'hA5A5_A5A5;
    tick();
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    check("mthi+mtlo idle", {bus.hi, bus.lo}, {32'hA5A5_A5A5, 32'hA5A5_A5A5});
    m_hi = 32'hA5A5_A5A5;
    m_lo = 32'hA5A5_A5A5;

    bus.mtlo  = 1'b1;
    bus.wdata = 32'h0F0F_0F0F;
    tick();
    bus.mtlo = 1'b0;
    check("mtlo only", {bus.hi, bus.lo}, {32'hA5A5_A5A5, 32'h0F0F_0F0F});
    m_lo = 32'h0F0F_0F0F;

    model(2'b10, 32'hFFFF_FF9C, 32'h0000_0007, r_hi, r_lo, r_dz);
    exec("busy writes+restart", 2'b10, 32'hFFFF_FF9C, 32'h0000_0007, 1'b0, 1'b1, r_hi, r_lo, r_dz);

    exec("start+mt", 2'b01, 32'h0000_0002, 32'h0000_0003, 1'b1, 1'b0, 32'h0, 32'h6, 1'b0);

    bus.op    = 2'b10;
    bus.a     = 32'h0000_1000;
    bus.b     = 32'h0000_0003;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #2;
    check("async reset", {bus.busy, bus.done, bus.dz, bus.hi, bus.lo}, 64'd0);
    tick();
    rst_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    tick();
    exec("multu after reset", 2'b01, 32'd5, 32'd6, 1'b0, 1'b0, 32'h0, 32'd30, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
